// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC and opcodes
// common to the fetch unit and the control decoder.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_HALTED,
    S_FAULT
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_BNE  = 6'b110001;
  localparam logic [5:0] OP_BLTZ = 6'b110010;

  function automatic logic [31:0] br_offset(
    input logic [15:0] imm
  );
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: halt, jump, taken branch,
// sequential, in that priority.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [25:0] target,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        branch_ltz,
  input  logic        jump,
  input  logic        halt,
  input  logic        alu_zero,
  input  logic        rs_neg,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic taken;

  always_comb begin
    pc_plus4 = pc + 32'd4;
    taken = (branch_eq & alu_zero)
          | (branch_ne & ~alu_zero)
          | (branch_ltz & rs_neg);
    next_pc = pc_plus4;
    if (halt) begin
      next_pc = pc;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], target, 2'b00};
    end else if (taken) begin
      next_pc = pc_plus4 + br_offset(target[15:0]);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch FSM with imem
// request/valid handshake, one issue per fetched word.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        branch_ltz,
  input  logic        jump,
  input  logic        halt,
  input  logic        alu_zero,
  input  logic        rs_neg,
  input  logic        stall,
  output logic        halted,
  output logic        fetch_fault
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(IMEM_TIMEOUT - 1);

  fetch_state_t  state;
  logic [CW-1:0] cnt;
  logic [31:0]   next_pc;

  pc_next_sel u_sel (
    .pc         (pc),
    .target     (instr[25:0]),
    .branch_eq  (branch_eq),
    .branch_ne  (branch_ne),
    .branch_ltz (branch_ltz),
    .jump       (jump),
    .halt       (halt),
    .alu_zero   (alu_zero),
    .rs_neg     (rs_neg),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc)
  );

  // Request spans FETCH and WAIT so a 1-cycle memory answers in WAIT.
  assign imem_req    = (state == S_FETCH) || (state == S_WAIT);
  assign instr_valid = (state == S_ISSUE);
  assign imem_addr   = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      cnt         <= '0;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_valid) begin
            instr <= imem_rdata;
            state <= S_ISSUE;
          end else if (cnt == LAST) begin
            state       <= S_FAULT;
            halted      <= 1'b1;
            fetch_fault <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            if (halt) begin
              state  <= S_HALTED;
              halted <= 1'b1;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end
        S_HALTED, S_FAULT: state <= state;
        default: state <= S_FAULT;
      endcase
    end
  end

endmodule
